// File: rtl/tag_coincidence_gate.sv
// tag_coincidence_gate
//
// Counts rising-edge tags on two selected channels (A and B) and A/B
// coincidences within an inclusive time window, over consecutive gates of
// fixed length measured in tag time. One result record is emitted per
// closed gate.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   tag_valid_i             converted tag present this cycle
//   tag_channel_i           tag channel number
//   tag_rising_edge_i       1 = rising edge (falling tags ignored)
//   tag_time_i              tag time, non-decreasing
//   cfg_enable_i            0 = idle/cleared, 1 = run; cfg_* sampled on rise
//   cfg_channel_a_i/_b_i    selected channels A and B
//   cfg_window_i            coincidence window (inclusive), tag time units
//   cfg_gate_period_i       gate length, tag time units (0 = never start)
//   result_valid_o          one-cycle pulse, result_* valid
//   result_count_a_o/_b_o   rising tags on A/B in the closed gate
//   result_coinc_o          coincidences in the closed gate
//   result_gate_start_o     start time of the closed gate
//   result_flags_o          bit0 counter saturated, bit1 empty gates skipped
//
// State table
//   state    | meaning
//   ST_IDLE  | disabled; counters, last-time registers and gate cleared
//   ST_ARMED | config captured, waiting for first A/B tag to open a gate
//   ST_RUN   | gate open; A/B tags count and close/advance gates
//
// Pipeline: stage 1 registers the qualified tag together with the window
// hit and the gate close/skip compares; stage 2 updates counters, gate and
// FSM. Stage 1 evaluates against the stage-2 next-state values, so a tag
// arriving back-to-back sees the effect of the tag one cycle ahead of it.

module tag_coincidence_gate #(
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 5,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tag_valid_i,
  input  logic [CHANNEL_WIDTH-1:0] tag_channel_i,
  input  logic                     tag_rising_edge_i,
  input  logic [TIME_WIDTH-1:0]    tag_time_i,
  input  logic                     cfg_enable_i,
  input  logic [CHANNEL_WIDTH-1:0] cfg_channel_a_i,
  input  logic [CHANNEL_WIDTH-1:0] cfg_channel_b_i,
  input  logic [31:0]              cfg_window_i,
  input  logic [TIME_WIDTH-1:0]    cfg_gate_period_i,
  output logic                     result_valid_o,
  output logic [COUNT_WIDTH-1:0]   result_count_a_o,
  output logic [COUNT_WIDTH-1:0]   result_count_b_o,
  output logic [COUNT_WIDTH-1:0]   result_coinc_o,
  output logic [TIME_WIDTH-1:0]    result_gate_start_o,
  output logic [1:0]               result_flags_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Configuration shadow registers, loaded while idle with enable high so
  // that they are stable from the first ARMED cycle onward.
  // ---------------------------------------------------------------------
  logic [CHANNEL_WIDTH-1:0] chan_a_q, chan_b_q;
  logic [31:0]              window_q;
  logic [TIME_WIDTH-1:0]    period_q;
  logic                     cfg_load;

  assign cfg_load = (state_q == ST_IDLE) && cfg_enable_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chan_a_q <= '0;
      chan_b_q <= '0;
      window_q <= '0;
      period_q <= '0;
    end else if (cfg_load) begin
      chan_a_q <= cfg_channel_a_i;
      chan_b_q <= cfg_channel_b_i;
      window_q <= cfg_window_i;
      period_q <= cfg_gate_period_i;
    end
  end

  // ---------------------------------------------------------------------
  // Gate / counter state
  // ---------------------------------------------------------------------
  logic [TIME_WIDTH-1:0]  gate_start_q, gate_start_d;
  logic [COUNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [COUNT_WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic [COUNT_WIDTH-1:0] coinc_q, coinc_d;
  logic                   sat_q, sat_d;
  logic                   skipped_q, skipped_d;
  logic [TIME_WIDTH-1:0]  last_a_q, last_a_d;
  logic [TIME_WIDTH-1:0]  last_b_q, last_b_d;
  logic                   last_a_vld_q, last_a_vld_d;
  logic                   last_b_vld_q, last_b_vld_d;

  logic                   res_valid_q, res_valid_d;
  logic [COUNT_WIDTH-1:0] res_a_q, res_a_d;
  logic [COUNT_WIDTH-1:0] res_b_q, res_b_d;
  logic [COUNT_WIDTH-1:0] res_coinc_q, res_coinc_d;
  logic [TIME_WIDTH-1:0]  res_start_q, res_start_d;
  logic [1:0]             res_flags_q, res_flags_d;

  // ---------------------------------------------------------------------
  // Stage 1: qualify tag, window hit and gate compares
  // ---------------------------------------------------------------------
  logic                  tag_is_a, tag_is_b, tag_qual;
  logic [TIME_WIDTH-1:0] win_ext;
  logic [TIME_WIDTH-1:0] diff_a, diff_b;
  logic [TIME_WIDTH-1:0] gate_end_d;
  logic                  tag_hit, tag_close, tag_skip;

  assign tag_is_a = (tag_channel_i == chan_a_q);
  assign tag_is_b = (tag_channel_i == chan_b_q);
  assign tag_qual = cfg_enable_i && (state_q != ST_IDLE) && tag_valid_i &&
                    tag_rising_edge_i && (tag_is_a || tag_is_b);

  assign win_ext    = TIME_WIDTH'(window_q);
  assign diff_a     = tag_time_i - last_a_d;
  assign diff_b     = tag_time_i - last_b_d;
  assign gate_end_d = gate_start_d + period_q;

  // When A and B are the same channel both terms reduce to the same test
  // against the shared previous tag, so the hit is still counted once.
  assign tag_hit   = (tag_is_a && last_b_vld_d && (diff_b <= win_ext)) ||
                     (tag_is_b && last_a_vld_d && (diff_a <= win_ext));
  assign tag_close = (tag_time_i >= gate_end_d);
  // At or beyond the end of the following gate, at least one empty gate
  // lies between the closed gate and this tag.
  assign tag_skip  = (tag_time_i >= (gate_end_d + period_q));

  logic                  s1_valid_q;
  logic                  s1_is_a_q, s1_is_b_q;
  logic                  s1_hit_q, s1_close_q, s1_skip_q;
  logic [TIME_WIDTH-1:0] s1_time_q;
  logic [TIME_WIDTH-1:0] s1_end_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_is_a_q  <= 1'b0;
      s1_is_b_q  <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_close_q <= 1'b0;
      s1_skip_q  <= 1'b0;
      s1_time_q  <= '0;
      s1_end_q   <= '0;
    end else begin
      s1_valid_q <= tag_qual;
      s1_is_a_q  <= tag_is_a;
      s1_is_b_q  <= tag_is_b;
      s1_hit_q   <= tag_hit;
      s1_close_q <= tag_close;
      s1_skip_q  <= tag_skip;
      s1_time_q  <= tag_time_i;
      s1_end_q   <= gate_end_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: FSM, gate advance, counters, result capture
  // ---------------------------------------------------------------------
  logic count_en;

  always_comb begin
    state_d      = state_q;
    gate_start_d = gate_start_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;
    coinc_d      = coinc_q;
    sat_d        = sat_q;
    skipped_d    = skipped_q;
    last_a_d     = last_a_q;
    last_b_d     = last_b_q;
    last_a_vld_d = last_a_vld_q;
    last_b_vld_d = last_b_vld_q;
    res_valid_d  = 1'b0;
    res_a_d      = res_a_q;
    res_b_d      = res_b_q;
    res_coinc_d  = res_coinc_q;
    res_start_d  = res_start_q;
    res_flags_d  = res_flags_q;
    count_en     = 1'b0;

    if (!cfg_enable_i) begin
      state_d      = ST_IDLE;
      gate_start_d = '0;
      cnt_a_d      = '0;
      cnt_b_d      = '0;
      coinc_d      = '0;
      sat_d        = 1'b0;
      skipped_d    = 1'b0;
      last_a_d     = '0;
      last_b_d     = '0;
      last_a_vld_d = 1'b0;
      last_b_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          // A zero period never opens a gate.
          if (s1_valid_q && (period_q != '0)) begin
            state_d      = ST_RUN;
            gate_start_d = s1_time_q;
            skipped_d    = 1'b0;
            count_en     = 1'b1;
          end
        end
        ST_RUN: begin
          if (s1_valid_q) begin
            count_en = 1'b1;
            if (s1_close_q) begin
              res_valid_d  = 1'b1;
              res_a_d      = cnt_a_q;
              res_b_d      = cnt_b_q;
              res_coinc_d  = coinc_q;
              res_start_d  = gate_start_q;
              res_flags_d  = {skipped_q, sat_q};
              // The closing tag starts the next gate's counts.
              cnt_a_d      = '0;
              cnt_b_d      = '0;
              coinc_d      = '0;
              sat_d        = 1'b0;
              skipped_d    = s1_skip_q;
              gate_start_d = s1_skip_q ? s1_time_q : s1_end_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (count_en) begin
        if (s1_is_a_q) begin
          if (&cnt_a_d) sat_d = 1'b1;
          else          cnt_a_d = cnt_a_d + COUNT_WIDTH'(1);
          last_a_d     = s1_time_q;
          last_a_vld_d = 1'b1;
        end
        if (s1_is_b_q) begin
          if (&cnt_b_d) sat_d = 1'b1;
          else          cnt_b_d = cnt_b_d + COUNT_WIDTH'(1);
          last_b_d     = s1_time_q;
          last_b_vld_d = 1'b1;
        end
        if (s1_hit_q) begin
          if (&coinc_d) sat_d = 1'b1;
          else          coinc_d = coinc_d + COUNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      gate_start_q <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      coinc_q      <= '0;
      sat_q        <= 1'b0;
      skipped_q    <= 1'b0;
      last_a_q     <= '0;
      last_b_q     <= '0;
      last_a_vld_q <= 1'b0;
      last_b_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_start_q <= gate_start_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      coinc_q      <= coinc_d;
      sat_q        <= sat_d;
      skipped_q    <= skipped_d;
      last_a_q     <= last_a_d;
      last_b_q     <= last_b_d;
      last_a_vld_q <= last_a_vld_d;
      last_b_vld_q <= last_b_vld_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_coinc_q <= '0;
      res_start_q <= '0;
      res_flags_q <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_coinc_q <= res_coinc_d;
      res_start_q <= res_start_d;
      res_flags_q <= res_flags_d;
    end
  end

  assign result_valid_o      = res_valid_q;
  assign result_count_a_o    = res_a_q;
  assign result_count_b_o    = res_b_q;
  assign result_coinc_o      = res_coinc_q;
  assign result_gate_start_o = res_start_q;
  assign result_flags_o      = res_flags_q;

endmodule

// File: tb/tb_tag_coincidence_gate.sv
// Scoreboard bench for tag_coincidence_gate. A per-tag reference model pushes
// expected gate records (with expected arrival cycle); a monitor pops and
// compares on every result_valid pulse. A narrow COUNT_WIDTH makes counter
// saturation reachable.

module tb_tag_coincidence_gate;

  localparam int TW   = 64;
  localparam int CHW  = 5;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            tag_valid_i;
  logic [CHW-1:0]  tag_channel_i;
  logic            tag_rising_edge_i;
  logic [TW-1:0]   tag_time_i;
  logic            cfg_enable_i;
  logic [CHW-1:0]  cfg_channel_a_i;
  logic [CHW-1:0]  cfg_channel_b_i;
  logic [31:0]     cfg_window_i;
  logic [TW-1:0]   cfg_gate_period_i;
  logic            result_valid_o;
  logic [CW-1:0]   result_count_a_o;
  logic [CW-1:0]   result_count_b_o;
  logic [CW-1:0]   result_coinc_o;
  logic [TW-1:0]   result_gate_start_o;
  logic [1:0]      result_flags_o;

  tag_coincidence_gate #(
    .TIME_WIDTH(TW), .CHANNEL_WIDTH(CHW), .COUNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tag_valid_i(tag_valid_i), .tag_channel_i(tag_channel_i),
    .tag_rising_edge_i(tag_rising_edge_i), .tag_time_i(tag_time_i),
    .cfg_enable_i(cfg_enable_i), .cfg_channel_a_i(cfg_channel_a_i),
    .cfg_channel_b_i(cfg_channel_b_i), .cfg_window_i(cfg_window_i),
    .cfg_gate_period_i(cfg_gate_period_i),
    .result_valid_o(result_valid_o), .result_count_a_o(result_count_a_o),
    .result_count_b_o(result_count_b_o), .result_coinc_o(result_coinc_o),
    .result_gate_start_o(result_gate_start_o), .result_flags_o(result_flags_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          ca;
    int          cb;
    int          cc;
    logic [63:0] st;
    logic [1:0]  fl;
    int          cy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // ---------------- reference model ----------------
  int          m_a, m_b;
  logic [63:0] m_win, m_period;
  bit          m_run, m_sat, m_skip, m_lav, m_lbv;
  logic [63:0] m_start, m_la, m_lb;
  int          m_ca, m_cb, m_cc;

  task automatic model_clear();
    m_run = 0; m_sat = 0; m_skip = 0; m_lav = 0; m_lbv = 0;
    m_start = 0; m_la = 0; m_lb = 0; m_ca = 0; m_cb = 0; m_cc = 0;
  endtask

  task automatic bump(inout int c);
    if (c == CMAX) m_sat = 1;
    else c = c + 1;
  endtask

  task automatic model_tag(input int ch, input bit rise, input bit vld, input logic [63:0] t);
    bit ia, ib, hit;
    exp_t e;
    logic [63:0] gend;
    if (!(vld && rise)) return;
    ia = (ch == m_a);
    ib = (ch == m_b);
    if (!ia && !ib) return;
    if (m_period == 0) return;
    if (!m_run) begin
      m_run = 1; m_start = t; m_skip = 0;
    end else if (t >= m_start + m_period) begin
      e.ca = m_ca; e.cb = m_cb; e.cc = m_cc; e.st = m_start;
      e.fl = {m_skip, m_sat}; e.cy = cyc + 2;
      exp_q.push_back(e);
      gend = m_start + m_period;
      if (t < gend + m_period) begin m_start = gend; m_skip = 0; end
      else begin m_start = t; m_skip = 1; end
      m_ca = 0; m_cb = 0; m_cc = 0; m_sat = 0;
    end
    hit = (ia && m_lbv && (t - m_lb) <= m_win) || (ib && m_lav && (t - m_la) <= m_win);
    if (ia) bump(m_ca);
    if (ib) bump(m_cb);
    if (hit) bump(m_cc);
    if (ia) begin m_la = t; m_lav = 1; end
    if (ib) begin m_lb = t; m_lbv = 1; end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (result_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got result_valid=1 start=%0d, expected no result",
                 result_gate_start_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency_cycle", 64'(cyc), 64'(mon_e.cy));
        check("count_a", 64'(result_count_a_o), 64'(mon_e.ca));
        check("count_b", 64'(result_count_b_o), 64'(mon_e.cb));
        check("coinc", 64'(result_coinc_o), 64'(mon_e.cc));
        check("gate_start", result_gate_start_o, mon_e.st);
        check("flags", 64'(result_flags_o), 64'(mon_e.fl));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int ch, input bit rise, input bit vld, input logic [63:0] t);
    tag_valid_i       = vld;
    tag_channel_i     = ch[CHW-1:0];
    tag_rising_edge_i = rise;
    tag_time_i        = t;
    model_tag(ch, rise, vld, t);
    @(negedge clk_i);
    tag_valid_i = 1'b0;
  endtask

  task automatic configure(input int a, input int b, input logic [31:0] w, input logic [63:0] p);
    repeat (3) @(negedge clk_i);
    cfg_enable_i = 1'b0;
    @(negedge clk_i);
    cfg_channel_a_i   = a[CHW-1:0];
    cfg_channel_b_i   = b[CHW-1:0];
    cfg_window_i      = w;
    cfg_gate_period_i = p;
    cfg_enable_i      = 1'b1;
    model_clear();
    m_a = a; m_b = b; m_win = 64'(w); m_period = p;
    @(negedge clk_i);
    // Live config changes while enabled must have no effect.
    cfg_channel_a_i   = CHW'($urandom_range(31, 0));
    cfg_channel_b_i   = CHW'($urandom_range(31, 0));
    cfg_window_i      = $urandom;
    cfg_gate_period_i = 64'($urandom_range(500, 0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 64'(result_valid_o), 64'd0);
    check({tag, "_count_a"}, 64'(result_count_a_o), 64'd0);
    check({tag, "_count_b"}, 64'(result_count_b_o), 64'd0);
    check({tag, "_coinc"}, 64'(result_coinc_o), 64'd0);
    check({tag, "_start"}, result_gate_start_o, 64'd0);
    check({tag, "_flags"}, 64'(result_flags_o), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t;
    rst_i = 1'b1;
    tag_valid_i = 0; tag_channel_i = 0; tag_rising_edge_i = 0; tag_time_i = 0;
    cfg_enable_i = 0; cfg_channel_a_i = 0; cfg_channel_b_i = 0;
    cfg_window_i = 0; cfg_gate_period_i = 0;
    model_clear();
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset");
    rst_i = 1'b0;

    // Basic gate with one coincidence; close tag exactly at gate end.
    configure(0, 1, 10, 1000);
    send(0, 1, 1, 100); send(1, 1, 1, 105); send(0, 1, 1, 500);
    send(1, 1, 1, 900); send(0, 1, 1, 1100);

    // Skipped empty gates.
    configure(0, 1, 10, 1000);
    send(0, 1, 1, 100); send(1, 1, 1, 3500); send(0, 1, 1, 4500);

    // Window 0: exact match counts, off by one does not.
    configure(0, 1, 0, 1000);
    send(0, 1, 1, 200); send(1, 1, 1, 200); send(0, 1, 1, 1200);
    configure(0, 1, 0, 1000);
    send(0, 1, 1, 200); send(1, 1, 1, 201); send(0, 1, 1, 1200);

    // A == B.
    configure(3, 3, 5, 1000);
    send(3, 1, 1, 0); send(3, 1, 1, 4); send(3, 1, 1, 20); send(3, 1, 1, 1000);

    // Interleaved falling-edge and foreign-channel tags, including at gate end.
    configure(0, 1, 10, 1000);
    send(0, 1, 1, 100); send(7, 1, 1, 100); send(1, 0, 1, 104);
    send(1, 1, 1, 105); send(0, 0, 1, 300); send(0, 1, 1, 500);
    send(7, 1, 1, 600); send(1, 1, 1, 900); send(7, 1, 1, 1100);
    send(0, 0, 1, 1100); send(1, 1, 0, 1100); send(0, 1, 1, 1100);

    // Saturation, then a close exactly at end + period (skip boundary).
    configure(0, 1, 10, 100000);
    for (int i = 0; i < 140; i++) send(i % 2, 1, 1, 64'(i / 2));
    send(0, 1, 1, 200000); send(1, 1, 1, 300000);

    // Zero period: never emits.
    configure(0, 1, 10, 0);
    for (int i = 0; i < 10; i++) send(i % 2, 1, 1, 64'(i * 5000));

    // Enable drop mid-gate discards the open gate.
    configure(0, 1, 10, 1000);
    send(0, 1, 1, 50); send(1, 1, 1, 55);

    // Async reset mid-gate.
    configure(0, 1, 10, 1000);
    send(0, 1, 1, 5000); send(0, 1, 1, 5100); send(0, 1, 1, 5200);
    send(0, 1, 1, 5300); send(0, 1, 1, 5400);
    #2 rst_i = 1'b1;
    #1 check_outputs_zero("async_reset");
    check("pending_at_reset", 64'(exp_q.size()), 64'd0);
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b0;
    configure(0, 1, 10, 1000);
    send(0, 1, 1, 6000); send(0, 1, 1, 6010); send(1, 1, 1, 6012);
    send(0, 1, 1, 7000);

    // Randomized streams.
    for (int r = 0; r < 5; r++) begin
      int a, b;
      a = int'($urandom_range(3, 0));
      b = (r == 2) ? a : int'($urandom_range(3, 0));
      configure(a, b, 32'($urandom_range(20, 0)), 64'($urandom_range(300, 40)));
      t = 64'($urandom_range(1000, 0));
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(99, 0) < 3) t = t + 64'($urandom_range(2000, 400));
        else t = t + 64'($urandom_range(15, 0));
        if ($urandom_range(7, 0) == 0) @(negedge clk_i);
        send(int'($urandom_range(4, 0)), $urandom_range(3, 0) != 0,
             $urandom_range(7, 0) != 0, t);
      end
    end

    repeat (10) @(negedge clk_i);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tag_coincidence_gate.md
Name: tag_coincidence_gate

Overview:
- Sits directly downstream of si_tag_converter, alongside the interval monitor, in the clk domain.
- Consumes the converted tag stream: valid, channel, edge and 64-bit tag time.
- Counts rising-edge tags on two selected channels, and A/B coincidences within a programmable time window, over consecutive fixed-length gates measured in tag time.
- Emits one result record per closed gate for the control/status layer.

Parameters:
- TIME_WIDTH, 64, width of tag_time and gate arithmetic.
- CHANNEL_WIDTH, 5, width of channel numbers.
- COUNT_WIDTH, 32, width of each result counter.

Ports:
- clk  input  1  single clock; all logic in this domain.
- rst  input  1  asynchronous, active-high reset.
- tag_valid  input  1  converted tag present this cycle.
- tag_channel  input  CHANNEL_WIDTH  channel of the tag.
- tag_rising_edge  input  1  1 = rising edge; falling tags are ignored.
- tag_time  input  TIME_WIDTH  tag time; non-decreasing across tags.
- cfg_enable  input  1  0 = idle and cleared; 1 = run.
- cfg_channel_a  input  CHANNEL_WIDTH  channel A.
- cfg_channel_b  input  CHANNEL_WIDTH  channel B.
- cfg_window  input  32  coincidence window (inclusive), in tag time units, zero-extended.
- cfg_gate_period  input  TIME_WIDTH  gate length in tag time units.
- result_valid  output  1  one-cycle pulse; result_* valid.
- result_count_a  output  COUNT_WIDTH  channel A rising tags in the closed gate.
- result_count_b  output  COUNT_WIDTH  channel B rising tags in the closed gate.
- result_coinc  output  COUNT_WIDTH  coincidences in the closed gate.
- result_gate_start  output  TIME_WIDTH  start time of the closed gate.
- result_flags  output  2  bit0 = a counter saturated; bit1 = one or more empty gates skipped before this one.

Behaviour:
- Reset (async): all state and outputs = 0, FSM = IDLE. Applies mid-gate; partial gate discarded, no result emitted.
- cfg_* are sampled into internal copies when cfg_enable rises. Changes while enabled are ignored until the next enable.
- Qualified tag: tag_valid && tag_rising_edge; one accepted per cycle, back-to-back. No backpressure.
- FSM states:
  - IDLE: counters, last-time registers and valid flags cleared. Result outputs hold their last values. cfg_enable=1 -> ARMED.
  - ARMED: the first qualified tag on A or B sets gate_start = tag_time and is counted in the new gate -> RUN. If cfg_gate_period == 0, stay in ARMED forever and never emit.
  - RUN: gate_end = gate_start + cfg_gate_period (TIME_WIDTH wrap ignored; tag time does not wrap).
  - Any state: cfg_enable=0 -> IDLE next cycle. No result for the open gate.
- Gate close, in RUN, for a qualified A/B tag with tag_time >= gate_end:
  - Emit the closed gate's counts, start and flags.
  - If tag_time < gate_end + period: new gate_start = gate_end, flag bit1 = 0.
  - Otherwise: new gate_start = tag_time and bit1 = 1 in the next emitted result.
  - The closing tag belongs to the new gate. Counters restart at its contribution in the same cycle.
- Tags on channels other than A/B never close gates and are ignored entirely.
- Counting and coincidence for a tag at time t on A:
  - count_a++.
  - If last_b_valid && (t - last_b) <= window: coinc++.
  - Then last_a = t, last_a_valid = 1.
  - B is symmetric.
- If cfg_channel_a == cfg_channel_b:
  - The tag increments count_a and count_b.
  - coinc is evaluated once, against the previous tag on that channel; last_a and last_b both update.
- Coincidence arithmetic: unsigned TIME_WIDTH subtraction; equal times count (window 0 = exact match).
- Last-time registers persist across gate boundaries. A coincidence is attributed to the gate of the later tag.
- Counters saturate at 2^COUNT_WIDTH-1 and set flag bit0 for that gate.
- Pipeline:
  - Stage 1 registers the tag and computes differences and the gate compare.
  - Stage 2 updates counters and FSM.
  - result_valid is asserted 2 cycles after the closing tag's tag_valid cycle.
  - result_* hold until the next pulse.

Test Plan:
- period=1000, window=10, A=0, B=1, rising tags A@100, B@105, A@500, B@900, A@1100 -> result_valid 2 cycles after the A@1100 input with count_a=2, count_b=2, coinc=1, gate_start=100, flags=0.
- Same config, tags A@100, then B@3500 -> one result with count_a=1, count_b=0, coinc=0, start=100. The next result has start=3500 and flags bit1=1.
- window=0, tags A@200, B@200 on consecutive cycles, A@1200 -> coinc=1. Separately, B@201 instead of B@200 -> coinc=0.
- A=B=3, window=5, tags 3@0, 3@4, 3@20, 3@1000 -> count_a=count_b=3, coinc=1.
- Falling-edge tags, and rising tags on channel 7, interleaved every cycle -> counts unchanged versus the same stream without them; no gate closes on those tags.
- rst asserted asynchronously mid-gate after 5 A tags -> all outputs 0 immediately, no result_valid. After re-enable, the first gate counts only new tags.
